fir_xifu_scoreboard: RTL and testbench
======================================

Name: fir_xifu_scoreboard

Overview:
- Register-hazard scoreboard for the XIFU NB_REGS x 32 register file (3 read ports in EX, 1 write port in WB).
- Tracks in-flight writes per register between issue and writeback/kill.
- Stalls issue on RAW hazards against rs1, rs2 or rd-as-source (op_c), and on WAW counter saturation.
- Sits beside the decoder; gates the X-interface issue handshake.

Parameters:
- NB_REGS, 4, number of XIFU registers; must match the register file.
- MAX_INFLIGHT, 3, max outstanding writes per register and in total.
- RW, $clog2(NB_REGS), register index width (derived, not overridable).
- CW, $clog2(MAX_INFLIGHT+1), counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  decoder presents an instruction
- issue_ready_o  out  1  scoreboard accepts it (combinational from state and inputs)
- issue_rs1_i  in  RW  source 1 index
- issue_rs2_i  in  RW  source 2 index
- issue_rd_i  in  RW  destination index
- issue_use_rs1_i  in  1  rs1 is read
- issue_use_rs2_i  in  1  rs2 is read
- issue_use_rd_i  in  1  rd is read as accumulator source (op_c)
- issue_wr_rd_i  in  1  instruction writes rd
- wb_write_i  in  1  WB stage writes the register file this cycle
- wb_rd_i  in  RW  WB destination
- kill_i  in  1  in-flight write cancelled (commit kill)
- kill_rd_i  in  RW  destination of the killed instruction
- pending_o  out  NB_REGS  bit i = register i has pending writes
- inflight_o  out  CW  total outstanding writes
- busy_o  out  1  inflight_o != 0
- err_underflow_o  out  1  sticky: decrement of a zero counter

Behaviour:
- State: per-register counter cnt[i] (CW bits); total counter tot (CW bits); sticky error flag.
- Reset (async, rst_i=1): all counters 0, err_underflow_o=0. Hence pending_o=0, inflight_o=0, busy_o=0, issue_ready_o=1.
- Hazard terms:
  - raw = (use_rs1 & cnt[rs1]!=0) | (use_rs2 & cnt[rs2]!=0) | (use_rd & cnt[rd]!=0).
  - sat = wr_rd & (cnt[rd]==MAX_INFLIGHT | tot==MAX_INFLIGHT).
- issue_ready_o = ~raw & ~sat. It must not depend on wb_write_i or kill_i in the same cycle: no same-cycle bypass, because the register file read returns the old value during a write edge.
- issue_ready_o may be high while issue_valid_i is low.
- Increment: fire = issue_valid_i & issue_ready_o & issue_wr_rd_i. Increments cnt[issue_rd_i] and tot at the next edge.
- Decrement: wb_write_i decrements cnt[wb_rd_i] and tot. kill_i decrements cnt[kill_rd_i] and tot.
- Simultaneous events: compute per-register net delta = inc - wb - kill, each 0/1, range -2..+1; apply the net delta to both cnt and tot in one cycle.
  - Example: fire and wb on the same register leave it unchanged.
  - wb and kill on the same register decrement it by 2.
- Underflow: if a decrement would take any counter below 0, clamp it at 0 and set err_underflow_o. The flag clears only on reset.
- Overflow cannot occur: sat blocks it.
- Latency: issue/wb/kill take effect on pending_o, inflight_o and issue_ready_o one cycle after the edge.
- A stalled instruction issues in the cycle after its producer's WB edge.
- Reset mid-operation clears all state regardless of in-flight traffic. Later wb/kill for pre-reset instructions trigger the underflow flag; this is the expected diagnostic.

Decomposition:
- fir_xifu_pkg gains: fir_xifu_issue2sb_t (rs1, rs2, rd, use/wr flags) and fir_xifu_sb2issue_t (ready) for decoder wiring, plus constant XIFU_MAX_INFLIGHT.
- Sub-module fir_xifu_sb_counter: one per register and one for tot. Saturating up/down counter taking inc and dec[1:0] inputs, with an underflow output.

Test Plan:
- Reset → pending_o=0, inflight_o=0, busy_o=0, issue_ready_o=1, err_underflow_o=0.
- Issue wr rd=2; next cycle issue use_rs1, rs1=2 → ready=0 until wb_write_i, wb_rd_i=2. Ready=1 the cycle after the WB edge; pending_o=4'b0000.
- Issue wr rd=1 with wb_write_i, wb_rd_i=1 in the same cycle while cnt[1]=1 → cnt[1] stays 1, inflight_o stays 1.
- Three back-to-back wr rd=3 issues → inflight_o=3, fourth wr (rd=0) stalls (tot saturated). Issue with wr=0 and no hazard still accepted.
- cnt[0]=1; wb rd=0 and kill rd=0 in the same cycle → cnt[0]=0, err_underflow_o=1 and stays 1.
- use_rd=1, rd=1 with cnt[1]=1 → ready=0. Assert rst_i mid-stall → ready=1 immediately (async) and all counters 0.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// Shared XIFU types and constants: decoder <-> scoreboard wiring.
package fir_xifu_pkg;

  localparam int XIFU_NB_REGS      = 4;
  localparam int XIFU_RW           = $clog2(XIFU_NB_REGS);
  localparam int XIFU_MAX_INFLIGHT = 3;

  typedef struct packed {
    logic [XIFU_RW-1:0] rs1;
    logic [XIFU_RW-1:0] rs2;
    logic [XIFU_RW-1:0] rd;
    logic               use_rs1;
    logic               use_rs2;
    logic               use_rd;
    logic               wr_rd;
  } fir_xifu_issue2sb_t;

  typedef struct packed {
    logic ready;
  } fir_xifu_sb2issue_t;

endpackage

// File: rtl/fir_xifu_sb_counter.sv
// Saturating up/down counter; dec is a count (0..2) of simultaneous decrements.
module fir_xifu_sb_counter #(
  parameter int MAX = 3,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc,
  input  logic [1:0]    dec,
  output logic [CW-1:0] cnt,
  output logic          underflow
);

  logic [CW:0]   sum;
  logic [CW-1:0] cnt_d;

  always_comb begin
    sum       = {1'b0, cnt} + (CW+1)'(inc);
    underflow = 1'b0;
    if (sum < (CW+1)'(dec)) begin
      // clamp at zero; caller turns this into a sticky diagnostic
      cnt_d     = '0;
      underflow = 1'b1;
    end else if (sum - (CW+1)'(dec) > (CW+1)'(MAX)) begin
      cnt_d = CW'(MAX);
    end else begin
      cnt_d = CW'(sum - (CW+1)'(dec));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else       cnt <= cnt_d;
  end

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// Register-hazard scoreboard for the XIFU register file: counts in-flight
// writes per register and gates issue on RAW hazards and counter saturation.
module fir_xifu_scoreboard
  import fir_xifu_pkg::*;
#(
  parameter  int NB_REGS      = XIFU_NB_REGS,
  parameter  int MAX_INFLIGHT = XIFU_MAX_INFLIGHT,
  localparam int RW           = $clog2(NB_REGS),
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [RW-1:0]      issue_rs1_i,
  input  logic [RW-1:0]      issue_rs2_i,
  input  logic [RW-1:0]      issue_rd_i,
  input  logic               issue_use_rs1_i,
  input  logic               issue_use_rs2_i,
  input  logic               issue_use_rd_i,
  input  logic               issue_wr_rd_i,
  input  logic               wb_write_i,
  input  logic [RW-1:0]      wb_rd_i,
  input  logic               kill_i,
  input  logic [RW-1:0]      kill_rd_i,
  output logic [NB_REGS-1:0] pending_o,
  output logic [CW-1:0]      inflight_o,
  output logic               busy_o,
  output logic               err_underflow_o
);

  logic [NB_REGS-1:0][CW-1:0] cnt;
  logic [NB_REGS-1:0]         inc_r;
  logic [NB_REGS-1:0][1:0]    dec_r;
  logic [NB_REGS-1:0]         uf_r;
  logic [CW-1:0]              tot;
  logic [1:0]                 tot_dec;
  logic                       tot_uf;
  logic                       raw, rd_full, sat, fire;

  // Hazards look only at registered counts: the RF read sees the old value
  // during a write edge, so WB/kill must not bypass into ready.
  always_comb begin
    raw     = 1'b0;
    rd_full = 1'b0;
    for (int i = 0; i < NB_REGS; i++) begin
      if (issue_use_rs1_i && issue_rs1_i == RW'(i) && cnt[i] != '0) raw = 1'b1;
      if (issue_use_rs2_i && issue_rs2_i == RW'(i) && cnt[i] != '0) raw = 1'b1;
      if (issue_use_rd_i  && issue_rd_i  == RW'(i) && cnt[i] != '0) raw = 1'b1;
      if (issue_rd_i == RW'(i) && cnt[i] == CW'(MAX_INFLIGHT))      rd_full = 1'b1;
    end
    sat = issue_wr_rd_i & (rd_full | (tot == CW'(MAX_INFLIGHT)));
  end

  assign issue_ready_o = ~raw & ~sat;
  assign fire          = issue_valid_i & issue_ready_o & issue_wr_rd_i;

  always_comb begin
    for (int i = 0; i < NB_REGS; i++) begin
      inc_r[i] = fire & (issue_rd_i == RW'(i));
      dec_r[i] = 2'(wb_write_i & (wb_rd_i == RW'(i)))
               + 2'(kill_i & (kill_rd_i == RW'(i)));
    end
  end

  assign tot_dec = 2'(wb_write_i) + 2'(kill_i);

  for (genvar g = 0; g < NB_REGS; g++) begin : g_reg
    fir_xifu_sb_counter #(.MAX(MAX_INFLIGHT), .CW(CW)) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc       (inc_r[g]),
      .dec       (dec_r[g]),
      .cnt       (cnt[g]),
      .underflow (uf_r[g])
    );
    assign pending_o[g] = (cnt[g] != '0);
  end

  fir_xifu_sb_counter #(.MAX(MAX_INFLIGHT), .CW(CW)) u_tot (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc       (fire),
    .dec       (tot_dec),
    .cnt       (tot),
    .underflow (tot_uf)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_underflow_o <= 1'b0;
    else       err_underflow_o <= err_underflow_o | (|uf_r) | tot_uf;
  end

  assign inflight_o = tot;
  assign busy_o     = (tot != '0);

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// Directed scoreboard bench: stimulus queues expected outputs, a monitor
// compares them at the following negative clock edge.
module tb_fir_xifu_scoreboard;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       issue_valid_i, issue_ready_o;
  logic [1:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic       issue_use_rs1_i, issue_use_rs2_i, issue_use_rd_i, issue_wr_rd_i;
  logic       wb_write_i, kill_i;
  logic [1:0] wb_rd_i, kill_rd_i;
  logic [3:0] pending_o;
  logic [1:0] inflight_o;
  logic       busy_o, err_underflow_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rdy;
    logic [3:0] pend;
    logic [1:0] inf;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  fir_xifu_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i),
    .issue_use_rs1_i(issue_use_rs1_i), .issue_use_rs2_i(issue_use_rs2_i),
    .issue_use_rd_i(issue_use_rd_i), .issue_wr_rd_i(issue_wr_rd_i),
    .wb_write_i(wb_write_i), .wb_rd_i(wb_rd_i),
    .kill_i(kill_i), .kill_rd_i(kill_rd_i),
    .pending_o(pending_o), .inflight_o(inflight_o), .busy_o(busy_o),
    .err_underflow_o(err_underflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Monitor: consume every queued expectation at the negative edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (issue_ready_o !== e.rdy || pending_o !== e.pend || inflight_o !== e.inf ||
            busy_o !== (e.inf != 2'd0) || err_underflow_o !== e.err) begin
          errors++;
          $display("FAIL %s: got rdy=%b pend=%b inf=%0d busy=%b err=%b, want rdy=%b pend=%b inf=%0d busy=%b err=%b",
                   e.name, issue_ready_o, pending_o, inflight_o, busy_o, err_underflow_o,
                   e.rdy, e.pend, e.inf, (e.inf != 2'd0), e.err);
        end
      end
    end
  end

  task automatic expect_out(input string n, input logic rdy, input logic [3:0] p,
                            input logic [1:0] inf, input logic err);
    exp_t e;
    e.name = n; e.rdy = rdy; e.pend = p; e.inf = inf; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_use_rs1_i = 0; issue_use_rs2_i = 0;
    issue_use_rd_i = 0; issue_wr_rd_i = 0;
    issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
    wb_write_i = 0; wb_rd_i = 0; kill_i = 0; kill_rd_i = 0;
  endtask

  task automatic issue_wr(input logic [1:0] rd);
    issue_valid_i = 1; issue_wr_rd_i = 1; issue_rd_i = rd;
  endtask

  initial begin
    idle();
    rst_i = 1;
    cyc(); cyc();
    expect_out("reset", 1, 4'b0000, 0, 0);
    cyc();
    rst_i = 0;

    // RAW on rs1 released one cycle after WB edge
    cyc(); issue_wr(2);
    expect_out("issue_rd2", 1, 4'b0000, 0, 0);
    cyc(); idle(); issue_valid_i = 1; issue_use_rs1_i = 1; issue_rs1_i = 2;
    expect_out("raw_rs1_stall", 0, 4'b0100, 1, 0);
    cyc(); wb_write_i = 1; wb_rd_i = 2;
    expect_out("raw_no_bypass", 0, 4'b0100, 1, 0);
    cyc(); wb_write_i = 0;
    expect_out("raw_release", 1, 4'b0000, 0, 0);
    cyc(); idle();

    // fire and wb on the same register cancel
    issue_wr(1);
    expect_out("issue_rd1", 1, 4'b0000, 0, 0);
    cyc(); wb_write_i = 1; wb_rd_i = 1;
    expect_out("fire_wb_pre", 1, 4'b0010, 1, 0);
    cyc(); idle(); wb_write_i = 1; wb_rd_i = 1;
    expect_out("fire_wb_same", 1, 4'b0010, 1, 0);
    cyc(); idle();
    expect_out("drain_rd1", 1, 4'b0000, 0, 0);

    // total saturation
    issue_wr(3);
    expect_out("wr3_a", 1, 4'b0000, 0, 0);
    cyc();
    expect_out("wr3_b", 1, 4'b1000, 1, 0);
    cyc();
    expect_out("wr3_c", 1, 4'b1000, 2, 0);
    cyc(); issue_rd_i = 0;
    expect_out("tot_sat", 0, 4'b1000, 3, 0);
    cyc(); idle(); issue_valid_i = 1; issue_use_rs1_i = 1; issue_rs1_i = 0;
    issue_use_rs2_i = 1; issue_rs2_i = 1;
    expect_out("nowr_accept", 1, 4'b1000, 3, 0);
    cyc(); idle(); wb_write_i = 1; wb_rd_i = 3;
    expect_out("drain3_a", 1, 4'b1000, 3, 0);
    cyc();
    expect_out("drain3_b", 1, 4'b1000, 2, 0);
    cyc();
    expect_out("drain3_c", 1, 4'b1000, 1, 0);
    cyc(); idle();
    expect_out("drain3_done", 1, 4'b0000, 0, 0);

    // wb + kill on a count of one -> clamp and sticky error
    issue_wr(0);
    expect_out("issue_rd0", 1, 4'b0000, 0, 0);
    cyc(); idle(); wb_write_i = 1; wb_rd_i = 0; kill_i = 1; kill_rd_i = 0;
    expect_out("wb_kill_pre", 1, 4'b0001, 1, 0);
    cyc(); idle();
    expect_out("wb_kill_underflow", 1, 4'b0000, 0, 1);
    cyc();
    expect_out("err_sticky", 1, 4'b0000, 0, 1);

    // op_c hazard, then reset mid-stall
    issue_wr(1);
    expect_out("issue_rd1_b", 1, 4'b0000, 0, 1);
    cyc(); idle(); issue_valid_i = 1; issue_use_rd_i = 1; issue_rd_i = 1;
    expect_out("use_rd_stall", 0, 4'b0010, 1, 1);
    @(negedge clk_i); #1;
    rst_i = 1;
    expect_out("async_rst", 1, 4'b0000, 0, 0);
    cyc(); rst_i = 0; idle(); wb_write_i = 1; wb_rd_i = 1;
    expect_out("post_rst_wb", 1, 4'b0000, 0, 0);
    cyc(); idle();
    expect_out("post_rst_uf", 1, 4'b0000, 0, 1);
    cyc(); cyc();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
